// File: rtl/disp_share_pkg.sv
// Shared types and constants for the display time-sharing arbiter.
package disp_share_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StBlank
  } state_e;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned HEX_W  = 32;

  localparam logic [DIGITS-1:0] LES_IDLE = 8'hFF;
  localparam logic [HEX_W-1:0]  HEX_IDLE = 32'h0;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first requester after ptr (wrapping) among req & mask.
module rr_picker #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic [2:0]   ptr,
  output logic         found,
  output logic [2:0]   idx
);

  logic [N-1:0] cand;

  // Scan positions ptr+1, ptr+2, ... ptr+N (mod N); first candidate wins.
  always_comb begin
    cand  = req & mask;
    found = 1'b0;
    idx   = 3'd0;
    for (int unsigned k = 1; k <= N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && cand[i] && (((32'(ptr) + k) % N) == i)) begin
          found = 1'b1;
          idx   = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/disp_share_arb.sv
// Time-sharing arbiter for the 8-digit seven-segment display.
// Optional macro DISP_SHARE_ARB_BLANK_EN: insert a one-tick blank between
// two distinct owners.
module disp_share_arb
  import disp_share_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned DWELL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [N-1:0]     req,
  input  logic [N*32-1:0]  hexs_in,
  input  logic [N*8-1:0]   point_in,
  input  logic [N*8-1:0]   les_in,
  output logic [N-1:0]     gnt,
  output logic [2:0]       owner,
  output logic             busy,
  output logic [31:0]      Hexs,
  output logic [7:0]       Point,
  output logic [7:0]       Les
);

  state_e              state_q;
  logic [N-1:0]        gnt_q;
  logic [2:0]          owner_q;
  logic                busy_q;
  logic [3:0]          dwell_q;
  logic [2:0]          rr_q;
  logic [HEX_W-1:0]    hexs_q;
  logic [DIGITS-1:0]   point_q;
  logic [DIGITS-1:0]   les_q;

  logic [N-1:0]        pick_mask;
  logic                pick_found;
  logic [2:0]          pick_idx;
  logic [N-1:0]        pick_oh;
  logic                owner_req;
  logic [HEX_W-1:0]    sel_hexs;
  logic [DIGITS-1:0]   sel_point;
  logic [DIGITS-1:0]   sel_les;

  // While holding, the current owner is excluded so a switch always moves on.
  always_comb begin
    pick_mask = '1;
    if (state_q == StHold) begin
      pick_mask = ~gnt_q;
    end
  end

  rr_picker #(
    .N (N)
  ) u_picker (
    .req   (req),
    .mask  (pick_mask),
    .ptr   (rr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Owner-indexed views of the request and image buses.
  always_comb begin
    pick_oh   = '0;
    owner_req = 1'b0;
    sel_hexs  = HEX_IDLE;
    sel_point = '0;
    sel_les   = LES_IDLE;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick_idx == 3'(i)) begin
        pick_oh[i] = 1'b1;
      end
      if (owner_q == 3'(i)) begin
        owner_req = req[i];
        sel_hexs  = hexs_in[i*32 +: 32];
        sel_point = point_in[i*8 +: 8];
        sel_les   = les_in[i*8 +: 8];
      end
    end
  end

  // Arbitration FSM with registered grant/owner/busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      owner_q <= 3'd0;
      busy_q  <= 1'b0;
      dwell_q <= 4'd0;
      rr_q    <= 3'(N - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            state_q <= StHold;
            gnt_q   <= pick_oh;
            owner_q <= pick_idx;
            rr_q    <= pick_idx;
            busy_q  <= 1'b1;
            dwell_q <= 4'(DWELL);
          end
        end
        StHold: begin
          if (!owner_req || dwell_q == 4'd0) begin
            if (pick_found) begin
`ifdef DISP_SHARE_ARB_BLANK_EN
              state_q <= StBlank;
              gnt_q   <= '0;
              busy_q  <= 1'b0;
`else
              gnt_q   <= pick_oh;
              owner_q <= pick_idx;
              rr_q    <= pick_idx;
              dwell_q <= 4'(DWELL);
`endif
            end else if (!owner_req) begin
              // Released with nobody waiting.
              state_q <= StIdle;
              gnt_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              // Expired but uncontested: keep the owner, restart the dwell.
              dwell_q <= 4'(DWELL);
            end
          end else if (tick && dwell_q != 4'd0) begin
            dwell_q <= dwell_q - 4'd1;
          end
        end
`ifdef DISP_SHARE_ARB_BLANK_EN
        StBlank: begin
          if (tick) begin
            if (pick_found) begin
              state_q <= StHold;
              gnt_q   <= pick_oh;
              owner_q <= pick_idx;
              rr_q    <= pick_idx;
              busy_q  <= 1'b1;
              dwell_q <= 4'(DWELL);
            end else begin
              state_q <= StIdle;
            end
          end
        end
`endif
        default: begin
          state_q <= StIdle;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Display image register, one stage behind the grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hexs_q  <= HEX_IDLE;
      point_q <= '0;
      les_q   <= LES_IDLE;
    end else if (busy_q) begin
      hexs_q  <= sel_hexs;
      point_q <= sel_point;
      les_q   <= sel_les;
    end else begin
      hexs_q  <= HEX_IDLE;
      point_q <= '0;
      les_q   <= LES_IDLE;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign Hexs  = hexs_q;
  assign Point = point_q;
  assign Les   = les_q;

endmodule

// File: tb/tb_disp_share_arb.sv
// Directed bench for disp_share_arb (N=4, DWELL=3, default build).
module tb_disp_share_arb;

  localparam int unsigned N     = 4;
  localparam int unsigned DWELL = 3;

  logic            clk;
  logic            rst_n;
  logic            tick;
  logic [N-1:0]    req;
  logic [N*32-1:0] hexs_in;
  logic [N*8-1:0]  point_in;
  logic [N*8-1:0]  les_in;
  logic [N-1:0]    gnt;
  logic [2:0]      owner;
  logic            busy;
  logic [31:0]     Hexs;
  logic [7:0]      Point;
  logic [7:0]      Les;

  disp_share_arb #(
    .N     (N),
    .DWELL (DWELL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .req      (req),
    .hexs_in  (hexs_in),
    .point_in (point_in),
    .les_in   (les_in),
    .gnt      (gnt),
    .owner    (owner),
    .busy     (busy),
    .Hexs     (Hexs),
    .Point    (Point),
    .Les      (Les)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] img_hex [N];
  logic [7:0]  img_pt  [N];
  logic [7:0]  img_les [N];

  task automatic push(input string tag, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%0h required=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Advance n clocks; leave time 1 unit after the last rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] img(input int i);
    return {16'h0, img_hex[i], img_pt[i], img_les[i]};
  endfunction

  int cur;

  initial begin
    img_hex[0] = 32'h0000_00A5; img_pt[0] = 8'h01; img_les[0] = 8'h00;
    img_hex[1] = 32'h1111_2222; img_pt[1] = 8'h02; img_les[1] = 8'h0F;
    img_hex[2] = 32'h3333_4444; img_pt[2] = 8'h04; img_les[2] = 8'hF0;
    img_hex[3] = 32'h5555_6666; img_pt[3] = 8'h08; img_les[3] = 8'h3C;
    for (int i = 0; i < int'(N); i++) begin
      hexs_in[i*32 +: 32] = img_hex[i];
      point_in[i*8 +: 8]  = img_pt[i];
      les_in[i*8 +: 8]    = img_les[i];
    end
    rst_n = 1'b0;
    tick  = 1'b0;
    req   = '0;
    step(2);

    // Reset values.
    push("rst_busy_gnt_owner", {57'h0, 1'b0, 4'b0000, 3'd0});
    chk({57'h0, busy, gnt, owner});
    push("rst_display", {16'h0, 32'h0, 8'h00, 8'hFF});
    chk({16'h0, Hexs, Point, Les});

    // Idle with no requests.
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      push("idle_no_req", {51'h0, 1'b0, 4'b0000, 8'hFF});
      step(1);
      chk({51'h0, busy, gnt, Les});
    end

    // Single requester: grant at +1, image at +2.
    req = 4'b0001;
    push("req0_gnt", {56'h0, 1'b1, 3'd0, oh(0)});
    push("req0_disp_still_idle", {16'h0, 32'h0, 8'h00, 8'hFF});
    step(1);
    chk({56'h0, busy, owner, gnt});
    chk({16'h0, Hexs, Point, Les});
    push("req0_disp", img(0));
    step(1);
    chk({16'h0, Hexs, Point, Les});

    // Uncontested owner keeps the display across many ticks.
    for (int t = 0; t < 8; t++) begin
      push("req0_hold", {60'h0, oh(0)});
      pulse_tick();
      step(1);
      chk({60'h0, gnt});
    end

    // Release to idle; display goes idle one cycle later.
    req = 4'b0000;
    push("release_gnt", {59'h0, 1'b0, 4'b0000});
    step(1);
    chk({59'h0, busy, gnt});
    push("release_les", {56'h0, 8'hFF});
    step(1);
    chk({56'h0, Les});

    // Two requesters; last owner was 0, so requester 2 is next in order.
    req = 4'b0101;
    cur = 2;
    push("pair_first_gnt", {60'h0, oh(cur)});
    step(1);
    chk({60'h0, gnt});
    for (int r = 0; r < 4; r++) begin
      for (int t = 0; t < int'(DWELL); t++) begin
        push("pair_hold", {60'h0, oh(cur)});
        pulse_tick();
        chk({60'h0, gnt});
      end
      cur = (cur == 2) ? 0 : 2;
      push("pair_switch", {60'h0, oh(cur)});
      push("pair_onehot", 64'h1);
      step(1);
      chk({60'h0, gnt});
      chk({63'h0, $onehot(gnt)});
      push("pair_disp", img(cur));
      step(1);
      chk({16'h0, Hexs, Point, Les});
    end

    // Owner 2 drops mid-dwell with requester 1 waiting: immediate switch.
    pulse_tick();
    req = 4'b0010;
    push("drop_gnt", {60'h0, oh(1)});
    step(1);
    chk({60'h0, gnt});
    push("drop_disp", img(1));
    step(1);
    chk({16'h0, Hexs, Point, Les});

    // Hand over to owner 3, then reset while it holds.
    req = 4'b1000;
    push("own3_gnt", {57'h0, oh(3), 3'd3});
    step(1);
    chk({57'h0, gnt, owner});
    push("own3_disp", img(3));
    step(1);
    chk({16'h0, Hexs, Point, Les});
    rst_n = 1'b0;
    push("midrst_gnt_busy", {59'h0, 1'b0, 4'b0000});
    push("midrst_display", {16'h0, 32'h0, 8'h00, 8'hFF});
    step(1);
    chk({59'h0, busy, gnt});
    chk({16'h0, Hexs, Point, Les});

    // After reset, requester 0 wins first over 3.
    rst_n = 1'b1;
    req   = 4'b1001;
    push("postrst_gnt", {60'h0, oh(0)});
    step(1);
    chk({60'h0, gnt});

    if (sb.size() != 0) begin
      n_err++;
      $error("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
